// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM with shared prescaler/counter and double-buffered duty; define PWM_CENTER_EN for centre-aligned (triangle) counting
module pwm_multi_ch #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [PRESC_W-1:0]        presc_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      load_i,
  output logic                      pending_o,
  output logic                      period_o,
  output logic [CHANNELS-1:0]       pwm_o
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] active_q, active_d, shadow_q, shadow_d;
  logic pending_q, pending_d, period_q, period_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic tick, wrap;
  // >= lets a lowered divisor take effect on the next enabled clock
  assign tick = en_i && (presc_q >= presc_i);
`ifdef PWM_CENTER_EN
  logic dir_q, dir_d;
  always_comb begin
    dir_d = (tick && (dir_q ? cnt_q == '0 : cnt_q == CNT_MAX)) ? ~dir_q : dir_q;
    cnt_d = tick ? (dir_d ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1)) : cnt_q;
    wrap  = tick && dir_q && cnt_q == WIDTH'(1);
  end
  always_ff @(posedge clk) dir_q <= rst_i ? 1'b0 : dir_d;
`else
  always_comb begin
    cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
    wrap  = tick && cnt_q == CNT_MAX;
  end
`endif
  always_comb begin
    presc_d   = tick ? '0 : (en_i ? presc_q + PRESC_W'(1) : presc_q);
    shadow_d  = load_i ? duty_i : shadow_q;
    active_d  = wrap ? (load_i ? duty_i : shadow_q) : active_q;
    pending_d = wrap ? 1'b0 : (load_i ? 1'b1 : pending_q);
    period_d  = wrap;
    pwm_d     = '0;
    for (int k = 0; k < CHANNELS; k++)
      pwm_d[k] = en_i && (cnt_q < active_q[k*WIDTH +: WIDTH]);
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      period_q  <= 1'b0;
      pwm_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      period_q  <= period_d;
      pwm_q     <= pwm_d;
    end
  end
  assign pending_o = pending_q;
  assign period_o  = period_q;
  assign pwm_o     = pwm_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed stimulus against an integer reference model of the sawtooth PWM
module tb_pwm_multi_ch;
  localparam int W = 8, C = 4, PW = 32, MAX = 255;
  logic clk = 0, rst_i = 1, en_i = 0, load_i = 0;
  logic [PW-1:0] presc_i = 0;
  logic [C*W-1:0] duty_i = 0;
  logic pending_o, period_o;
  logic [C-1:0] pwm_o;
  int tests = 0, fails = 0;
  int m_q = 0, m_cnt = 0, m_act[C], m_sh[C];
  bit m_pend = 0, e_period = 0, chk_en = 0;
  bit [C-1:0] e_pwm = 0;
  int hi[C], per;

  pwm_multi_ch #(.WIDTH(W), .CHANNELS(C), .PRESC_W(PW)) dut (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .presc_i(presc_i), .duty_i(duty_i),
    .load_i(load_i), .pending_o(pending_o), .period_o(period_o), .pwm_o(pwm_o)
  );

  always #5 clk = ~clk;

  // reference: duty counter as an integer modulo 2^W, outputs are registered views of the pre-edge state
  always @(posedge clk) begin
    bit tk, wr;
    int d;
    if (rst_i) begin
      m_q = 0; m_cnt = 0; m_pend = 0; e_period = 0; e_pwm = 0;
      for (int k = 0; k < C; k++) begin m_act[k] = 0; m_sh[k] = 0; end
    end else begin
      tk = en_i && (m_q >= presc_i);
      wr = tk && (m_cnt == MAX);
      for (int k = 0; k < C; k++) e_pwm[k] = en_i && (m_cnt < m_act[k]);
      e_period = wr;
      for (int k = 0; k < C; k++) begin
        d = int'(duty_i[k*W +: W]);
        if (wr) m_act[k] = load_i ? d : m_sh[k];
        if (load_i) m_sh[k] = d;
      end
      m_pend = wr ? 1'b0 : (load_i ? 1'b1 : m_pend);
      m_q = tk ? 0 : (en_i ? m_q + 1 : m_q);
      m_cnt = tk ? (m_cnt + 1) % (MAX + 1) : m_cnt;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("pwm", 32'(pwm_o), 32'(e_pwm));
    check("pending", 32'(pending_o), 32'(m_pend));
    check("period", 32'(period_o), 32'(e_period));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_period(output int n);
    n = 0;
    do begin step(); n++; end while (!period_o && n < 3000);
    if (!period_o) begin tests++; fails++; $display("FAIL period_timeout: no period_o within %0d clocks", n); end
  endtask

  task automatic wait_cnt(input int v, output int n);
    n = 0;
    while (m_cnt != v && n < 3000) begin step(); n++; end
    if (m_cnt != v) begin tests++; fails++; $display("FAIL cnt_timeout: count %0d never reached", v); end
  endtask

  task automatic window();
    per = 0;
    for (int k = 0; k < C; k++) hi[k] = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      for (int k = 0; k < C; k++) hi[k] += int'(pwm_o[k]);
      per += int'(period_o);
    end
  endtask

  initial begin
    int n, n1, n2;
    rst_i = 1; en_i = 1; load_i = 1; duty_i = '1; presc_i = 0;
    @(posedge clk);
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pwm", 32'(pwm_o), 0);
      check("rst_pending", 32'(pending_o), 0);
      check("rst_period", 32'(period_o), 0);
    end
    rst_i = 0; load_i = 1; duty_i = {8'd255, 8'd0, 8'd128, 8'd64};
    step();
    load_i = 0;
    check("load_pending", 32'(pending_o), 1);
    wait_period(n);
    check("first_period_len", 32'(n + 1), 256);
    check("wrap_clears_pending", 32'(pending_o), 0);
    window();
    check("ch0_high", 32'(hi[0]), 64);
    check("ch1_high", 32'(hi[1]), 128);
    check("ch2_high", 32'(hi[2]), 0);
    check("ch3_high", 32'(hi[3]), 255);
    check("period_pulses", 32'(per), 1);
    wait_cnt(50, n);
    duty_i[7:0] = 8'd200; load_i = 1;
    step();
    load_i = 0;
    check("shadow_pending", 32'(pending_o), 1);
    wait_period(n);
    check("shadow_pending_clr", 32'(pending_o), 0);
    window();
    check("ch0_after_shadow", 32'(hi[0]), 200);
    wait_cnt(255, n);
    duty_i[7:0] = 8'd10; load_i = 1;
    step();
    load_i = 0;
    check("wrap_load_period", 32'(period_o), 1);
    check("wrap_load_pending", 32'(pending_o), 0);
    window();
    check("ch0_wrap_load", 32'(hi[0]), 10);
    presc_i = 3;
    wait_period(n);
    wait_period(n);
    check("presc3_period", 32'(n), 1024);
    presc_i = 9;
    n = 0;
    while (m_q != 5 && n < 100) begin step(); n++; end
    check("reach_q5", 32'(m_q), 5);
    presc_i = 2;
    repeat (40) step();
    presc_i = 0;
    wait_period(n);
    wait_cnt(100, n1);
    en_i = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("en_low_pwm", 32'(pwm_o), 0);
    end
    en_i = 1;
    wait_period(n2);
    check("enable_stretch", 32'(n1 + 20 + n2), 276);
    wait_cnt(30, n);
    duty_i[7:0] = 8'd77; load_i = 1;
    step();
    load_i = 0;
    rst_i = 1;
    step();
    check("mid_rst_pwm", 32'(pwm_o), 0);
    check("mid_rst_pending", 32'(pending_o), 0);
    rst_i = 0;
    wait_period(n);
    check("post_rst_period", 32'(n), 256);
    repeat (10) step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Multi-channel PWM generator driven by one shared prescaler and one shared duty counter. Per-channel duty values are double-buffered, so updates take effect only at the period boundary and never cause glitches. This is the next-generation PWM block for the design. It generalises resolution, channel count and prescaler width, and adds enable, runtime prescaler and period-strobe behaviour.

Parameters:
WIDTH, 8, duty/counter resolution in bits; period = 2^WIDTH ticks
CHANNELS, 4, number of independent PWM outputs
PRESC_W, 32, prescaler counter and presc_i width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
en_i  input  1  run enable; low freezes counting and forces outputs low
presc_i  input  PRESC_W  tick divisor; one tick every presc_i+1 clocks
duty_i  input  CHANNELS*WIDTH  packed duty values; channel k = bits [k*WIDTH +: WIDTH]
load_i  input  1  single-cycle strobe; captures duty_i into the shadow registers
pending_o  output  1  high while shadow values wait for the period boundary
period_o  output  1  one-clock pulse at each period wrap
pwm_o  output  CHANNELS  registered PWM outputs

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - prescaler, duty counter, active duty, shadow duty all cleared to 0
  - pwm_o=0, pending_o=0, period_o=0
  - rst_i has priority over every other input, including mid-period
- Prescaler q (PRESC_W bits):
  - tick = en_i && (q >= presc_i)
  - on tick: q<=0; else if en_i: q<=q+1
  - Using >= (not ==) means lowering presc_i below the current q gives a tick on the next enabled cycle, with no 2^PRESC_W runaway
  - presc_i=0 gives a tick every enabled clock
- Duty counter cnt (WIDTH bits):
  - increments on tick; wraps from 2^WIDTH-1 to 0
  - wrap event = tick && cnt==2^WIDTH-1
- Shadow/active registers:
  - load_i=1 without a wrap event: shadow<=duty_i, pending_o<=1
  - wrap event without load_i: active<=shadow, pending_o<=0
  - load_i and a wrap event in the same cycle: active<=duty_i, shadow<=duty_i, pending_o<=0 (the new value takes effect at this wrap)
  - a repeated load_i before the wrap overwrites shadow; last value wins
- Output compare:
  - pwm_o[k] <= en_i && (cnt < active[k]); unsigned compare at WIDTH bits
  - pwm_o lags cnt by one clock
  - active=0: output constantly low
  - active=2^WIDTH-1: output high for 2^WIDTH-1 of 2^WIDTH ticks; 100% duty is not reachable
- period_o <= wrap event (registered, one clock wide).
- en_i=0:
  - q and cnt hold their values; pwm_o<=0
  - load_i still updates shadow; no wrap can occur
  - en_i returning to 1 resumes from the held q/cnt

Optional Feature:
Macro PWM_CENTER_EN.
- Defined: cnt counts up/down (triangle).
  - Counts 0 up to 2^WIDTH-1, then down to 0.
  - Direction flips at each end on tick.
  - Period = 2*(2^WIDTH-1) ticks.
  - Wrap event = tick && cnt==1 && direction down (cnt reaching 0); shadow transfer and period_o follow this event.
  - Outputs are centre-aligned; the compare rule is unchanged.
  - Reset direction = up.
- Undefined: sawtooth as described above; no direction register is synthesised.

Test Plan:
1. Reset: hold rst_i=1 for 3 clocks with load_i=1 and en_i=1 -> pwm_o=0, pending_o=0, period_o=0; after release, cnt starts at 0.
2. Basic duty: WIDTH=8, presc_i=0, en_i=1, load ch0=64, ch1=128 -> after the first wrap, ch0 high exactly 64 clocks and ch1 128 clocks of each 256; period_o pulses every 256 clocks.
3. Extremes: ch2=0, ch3=255 -> ch2 never high; ch3 low exactly 1 clock per 256-clock period.
4. Shadow timing: load ch0=200 at cnt=50 -> pending_o=1, ch0 keeps its old duty until the wrap; new duty applies from the next period and pending_o clears at the wrap. A load on the wrap cycle itself takes effect immediately.
5. Prescaler:
   - presc_i=3 -> tick every 4 clocks, period 1024 clocks.
   - Change presc_i from 9 to 2 while q=5 -> tick on the next clock, then every 3 clocks.
6. Enable: drop en_i at cnt=100 for 20 clocks -> pwm_o=0, cnt stays at 100; on re-enable, counting resumes from 100 and the period end is delayed by 20 clocks.
